// File: rtl/lsu_memreq.sv
// lsu_memreq: RISC-V load/store initiator in front of a word-wide memacc memory.
// Each request runs as one transaction. Word stores write directly. Sub-word
// stores read the word, merge the new bytes, then write it back. Loads read the
// word, then select the byte lane and sign- or zero-extend it. Misaligned
// requests, illegal funct3 codes and read timeouts complete with an error
// response and never write memory.
module lsu_memreq #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic        o_mem_enable,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_write_enable,
    output logic [31:0] o_mem_data_out,
    input  logic        i_mem_data_in_v,
    input  logic [31:0] i_mem_data_in
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Illegal funct3: loads allow 000/001/010/100/101, stores allow 000/001/010.
    function automatic logic f_is_illegal(input logic st, input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        if (st) begin
            bad = f3[2] || (f3[1:0] == 2'b11);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    function automatic logic f_is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] f_load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                   input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {a, 3'b000};
        res = 32'h0000_0000;
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b010:  res = word;
            3'b100:  res = {24'h00_0000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace the addressed byte (SB) or halfword (SH) of the old word.
    function automatic logic [31:0] f_store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [31:0] old_word,
                                                  input logic [31:0] wdata);
        logic [4:0]  shamt;
        logic [31:0] mask;
        logic [31:0] res;
        shamt = 5'd0;
        mask  = 32'h0000_0000;
        res   = wdata;
        case (f3[1:0])
            2'b00: begin
                shamt = {a, 3'b000};
                mask  = 32'h0000_00FF << shamt;
                res   = (old_word & ~mask) | ((wdata & 32'h0000_00FF) << shamt);
            end
            2'b01: begin
                shamt = {a[1], 4'b0000};
                mask  = 32'h0000_FFFF << shamt;
                res   = (old_word & ~mask) | ((wdata & 32'h0000_FFFF) << shamt);
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    state_t       r_state;
    logic         r_store;
    logic [2:0]   r_funct3;
    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic [CW-1:0] r_cnt;

    logic         r_req_ready;
    logic         r_resp_valid;
    logic [31:0]  r_resp_rdata;
    logic         r_resp_error;
    logic         r_mem_enable;
    logic [31:0]  r_mem_addr;
    logic         r_mem_write_enable;
    logic [31:0]  r_mem_data_out;

    logic         w_accept;
    logic         w_req_bad;
    logic         w_req_sw;
    logic [31:0]  w_load_data;
    logic [31:0]  w_merge_data;

    assign w_accept     = i_req_valid && r_req_ready;
    assign w_req_bad    = f_is_illegal(i_req_store, i_req_funct3) ||
                          f_is_misaligned(i_req_funct3, i_req_addr[1:0]);
    assign w_req_sw     = i_req_store && (i_req_funct3 == 3'b010);
    assign w_load_data  = f_load_extract(r_funct3, r_addr[1:0], i_mem_data_in);
    assign w_merge_data = f_store_merge(r_funct3, r_addr[1:0], i_mem_data_in, r_wdata);

    assign o_req_ready        = r_req_ready;
    assign o_resp_valid       = r_resp_valid;
    assign o_resp_rdata       = r_resp_rdata;
    assign o_resp_error       = r_resp_error;
    assign o_mem_enable       = r_mem_enable;
    assign o_mem_addr         = r_mem_addr;
    assign o_mem_write_enable = r_mem_write_enable;
    assign o_mem_data_out     = r_mem_data_out;

    // Transaction FSM; every output is registered and updated on the state change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state            <= IDLE;
            r_store            <= 1'b0;
            r_funct3           <= 3'b000;
            r_addr             <= 32'h0000_0000;
            r_wdata            <= 32'h0000_0000;
            r_cnt              <= '0;
            r_req_ready        <= 1'b1;
            r_resp_valid       <= 1'b0;
            r_resp_rdata       <= 32'h0000_0000;
            r_resp_error       <= 1'b0;
            r_mem_enable       <= 1'b0;
            r_mem_addr         <= 32'h0000_0000;
            r_mem_write_enable <= 1'b0;
            r_mem_data_out     <= 32'h0000_0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_store     <= i_req_store;
                        r_funct3    <= i_req_funct3;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        if (w_req_bad) begin
                            // Rejected without touching memory.
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                            r_resp_error <= 1'b1;
                        end else if (w_req_sw) begin
                            r_state            <= WRITE;
                            r_mem_enable       <= 1'b1;
                            r_mem_write_enable <= 1'b1;
                            r_mem_addr         <= {i_req_addr[31:2], 2'b00};
                            r_mem_data_out     <= i_req_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            r_state            <= READ;
                            r_mem_enable       <= 1'b1;
                            r_mem_write_enable <= 1'b0;
                            r_mem_addr         <= {i_req_addr[31:2], 2'b00};
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                READ: begin
                    if (i_mem_data_in_v) begin
                        if (r_store) begin
                            r_state            <= WRITE;
                            r_mem_write_enable <= 1'b1;
                            r_mem_addr         <= {r_addr[31:2], 2'b00};
                            r_mem_data_out     <= w_merge_data;
                        end else begin
                            r_state      <= DONE;
                            r_mem_enable <= 1'b0;
                            r_mem_addr   <= 32'h0000_0000;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_load_data;
                            r_resp_error <= 1'b0;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // Memory never answered: abort without writing.
                        r_state      <= DONE;
                        r_mem_enable <= 1'b0;
                        r_mem_addr   <= 32'h0000_0000;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= 32'h0000_0000;
                        r_resp_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WRITE: begin
                    r_state            <= DONE;
                    r_mem_enable       <= 1'b0;
                    r_mem_write_enable <= 1'b0;
                    r_mem_addr         <= 32'h0000_0000;
                    r_mem_data_out     <= 32'h0000_0000;
                    r_resp_valid       <= 1'b1;
                    r_resp_rdata       <= 32'h0000_0000;
                    r_resp_error       <= 1'b0;
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_resp_error <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state            <= IDLE;
                    r_req_ready        <= 1'b1;
                    r_resp_valid       <= 1'b0;
                    r_resp_rdata       <= 32'h0000_0000;
                    r_resp_error       <= 1'b0;
                    r_mem_enable       <= 1'b0;
                    r_mem_addr         <= 32'h0000_0000;
                    r_mem_write_enable <= 1'b0;
                    r_mem_data_out     <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_memreq.sv
// Scoreboard bench for lsu_memreq. The driver pushes hand-computed expected
// responses and memory writes; independent monitors pop and compare them when
// the DUT presents resp_valid or a memory write. A small word memory answers
// reads either one cycle late, in the same cycle, or never.
module tb_lsu_memreq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [31:0] mem_data_out;
    logic        mem_data_in_v;
    logic [31:0] mem_data_in;

    lsu_memreq #(.TIMEOUT(16)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_store        (req_store),
        .i_req_funct3       (req_funct3),
        .i_req_addr         (req_addr),
        .i_req_wdata        (req_wdata),
        .o_resp_valid       (resp_valid),
        .o_resp_rdata       (resp_rdata),
        .o_resp_error       (resp_error),
        .o_mem_enable       (mem_enable),
        .o_mem_addr         (mem_addr),
        .o_mem_write_enable (mem_write_enable),
        .o_mem_data_out     (mem_data_out),
        .i_mem_data_in_v    (mem_data_in_v),
        .i_mem_data_in      (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed { logic [31:0] rdata; logic err; } resp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    resp_t exp_resp[$];
    wr_t   exp_wr[$];

    // Memory model: mode 0 = valid one cycle after enable, 1 = same cycle, 2 = never.
    logic [31:0] mem [0:15];
    int          mode = 0;
    logic        preload = 1'b0;
    logic        r_v = 1'b0;
    logic [31:0] r_d = 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'hCDEF_CDEF;
        end else if (mem_enable && mem_write_enable) begin
            mem[mem_addr[5:2]] <= mem_data_out;
        end
        r_v <= (mode == 0) && mem_enable && !mem_write_enable;
        r_d <= mem[mem_addr[5:2]];
    end

    assign mem_data_in_v = (mode == 1) ? (mem_enable && !mem_write_enable) :
                           (mode == 0) ? r_v : 1'b0;
    assign mem_data_in   = (mode == 1) ? mem[mem_addr[5:2]] : r_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: compare each resp_valid pulse with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_resp.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL resp_unexpected: got rdata %h err %b expected none",
                         resp_rdata, resp_error);
            end else begin
                resp_t e;
                e = exp_resp.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_error", {31'h0, resp_error}, {31'h0, e.err});
            end
        end
    end

    // Write monitor: every memory write must match the next expected write.
    always @(negedge clk) begin
        if (mem_enable && mem_write_enable) begin
            if (exp_wr.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL write_unexpected: got addr %h data %h expected none",
                         mem_addr, mem_data_out);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_data_out, w.data);
            end
        end
    end

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int k;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_wait: got req_ready 0 expected 1");
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Issue one request; check latency (cycles from accept to resp) and enable cycles.
    task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_en,
                          input logic has_wr, input logic [31:0] wr_data);
        int lat;
        int en;
        resp_t r;
        wr_t   w;
        r.rdata = exp_rd;
        r.err   = exp_err;
        exp_resp.push_back(r);
        if (has_wr) begin
            w.addr = {a[31:2], 2'b00};
            w.data = wr_data;
            exp_wr.push_back(w);
        end
        drive(st, f3, a, wd);
        lat = -1;
        en  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_enable) en++;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_enables"}, 32'(en), 32'(exp_en));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data_out", mem_data_out, 32'h0);
        rst = 1'b0;

        // Memory answers one cycle after enable.
        mode = 0;
        do_req("sw4",   1'b1, 3'b010, 32'd4,  32'hABCD_ABCD, 32'h0,         1'b0, 2, 1, 1'b1, 32'hABCD_ABCD);
        do_req("lw4",   1'b0, 3'b010, 32'd4,  32'h0,         32'hABCD_ABCD, 1'b0, 3, 2, 1'b0, 32'h0);
        do_req("lb9",   1'b0, 3'b000, 32'd9,  32'h0,         32'hFFFF_FFCD, 1'b0, 3, 2, 1'b0, 32'h0);
        do_req("lbu9",  1'b0, 3'b100, 32'd9,  32'h0,         32'h0000_00CD, 1'b0, 3, 2, 1'b0, 32'h0);
        do_req("lh10",  1'b0, 3'b001, 32'd10, 32'h0,         32'hFFFF_CDEF, 1'b0, 3, 2, 1'b0, 32'h0);
        do_req("lhu10", 1'b0, 3'b101, 32'd10, 32'h0,         32'h0000_CDEF, 1'b0, 3, 2, 1'b0, 32'h0);
        do_req("sb10",  1'b1, 3'b000, 32'd10, 32'h0000_0012, 32'h0,         1'b0, 4, 3, 1'b1, 32'hCD12_CDEF);
        do_req("sh8",   1'b1, 3'b001, 32'd8,  32'h0000_3456, 32'h0,         1'b0, 4, 3, 1'b1, 32'hCD12_3456);
        do_req("lw6",   1'b0, 3'b010, 32'd6,  32'h0,         32'h0,         1'b1, 1, 0, 1'b0, 32'h0);
        do_req("sh5",   1'b1, 3'b001, 32'd5,  32'h0000_1111, 32'h0,         1'b1, 1, 0, 1'b0, 32'h0);
        do_req("ld011", 1'b0, 3'b011, 32'd0,  32'h0,         32'h0,         1'b1, 1, 0, 1'b0, 32'h0);
        do_req("st100", 1'b1, 3'b100, 32'd0,  32'h0000_0055, 32'h0,         1'b1, 1, 0, 1'b0, 32'h0);

        // Memory answers in the first READ cycle.
        mode = 1;
        do_req("lw8i",  1'b0, 3'b010, 32'd8,  32'h0,         32'hCD12_3456, 1'b0, 2, 1, 1'b0, 32'h0);
        do_req("sb11i", 1'b1, 3'b000, 32'd11, 32'hFFFF_FF77, 32'h0,         1'b0, 3, 2, 1'b1, 32'h7712_3456);
        do_req("lh8i",  1'b0, 3'b001, 32'd8,  32'h0,         32'h0000_3456, 1'b0, 2, 1, 1'b0, 32'h0);

        // Memory never answers: timeout after 16 READ cycles.
        mode = 2;
        do_req("lw_to", 1'b0, 3'b010, 32'd8,  32'h0,         32'h0,         1'b1, 17, 16, 1'b0, 32'h0);
        do_req("sb_to", 1'b1, 3'b000, 32'd0,  32'h0000_0099, 32'h0,         1'b1, 17, 16, 1'b0, 32'h0);

        // Reset during the READ phase of an SB.
        drive(1'b1, 3'b000, 32'd0, 32'h0000_00AA);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_enable", {31'h0, mem_enable}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("mid_rst_enable", {31'h0, mem_enable}, 32'h0);
        chk("mid_rst_we", {31'h0, mem_write_enable}, 32'h0);
        chk("mid_rst_resp", {31'h0, resp_valid}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_word0", mem[0], 32'h0);

        // Recovery after reset.
        mode = 0;
        do_req("lw8r",  1'b0, 3'b010, 32'd8,  32'h0,         32'h7712_3456, 1'b0, 3, 2, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'h0);
        chk("write_queue_empty", 32'(exp_wr.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_memreq.md
Name: lsu_memreq

Overview:
- Load/store initiator that sits between the execute stage and the `memacc` word memory.
- Takes one RISC-V load/store request per transaction: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Issues word-aligned reads and writes on the memacc-style port (`enable`, `addr`, `write_enable`, `data_in` / `data_out_v`, `data_out`).
- Performs byte-lane extraction with sign/zero extension. Sub-word stores use read-modify-write.

Parameters:
- TIMEOUT, 16: maximum READ-state cycles to wait for mem_data_in_v before aborting with error.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (width and signedness)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle pulse, transaction complete
- resp_rdata  out  32  extended load data, 0 for stores and errors
- resp_error  out  1  valid with resp_valid: misaligned, illegal funct3, or timeout
- mem_enable  out  1  memory access request
- mem_addr  out  32  word address: {req_addr[31:2], 2'b00}
- mem_write_enable  out  1  1 = write word
- mem_data_out  out  32  write word, drives memacc data_in
- mem_data_in_v  in  1  read data valid, from memacc data_out_v
- mem_data_in  in  32  read word, from memacc data_out

Behaviour:
- Reset values:
  - state = IDLE, req_ready = 1.
  - All other outputs 0.
  - Latched request registers and timeout counter cleared.
- Reset mid-transaction: return to IDLE on that edge; no further memory write is issued.
- States: IDLE, READ, WRITE, DONE.
- Upstream handshake: request accepted on a clock edge with req_valid && req_ready. req_ready = 1 only in IDLE.
- IDLE, on accept: latch store, funct3, addr, wdata. Next state:
  - Illegal funct3 (load 011/110/111; store 1xx or 011) -> DONE, error = 1.
  - Misaligned (H with addr[0] = 1; W with addr[1:0] != 0) -> DONE, error = 1. No memory access.
  - SW -> WRITE.
  - Any load, or SB/SH -> READ.
- READ:
  - Outputs: mem_enable = 1, mem_write_enable = 0, mem_addr = aligned address.
  - Counter increments each cycle.
  - On mem_data_in_v, load: select lane and extend, then DONE.
    - Byte k sits at bits [8k+7:8k] (little-endian).
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - On mem_data_in_v, store: merge new bytes into mem_data_in, then WRITE.
    - SB replaces byte addr[1:0].
    - SH replaces half addr[1].
  - No valid within TIMEOUT cycles: go to DONE with error = 1. No write is issued.
- WRITE:
  - Outputs: mem_enable = 1, mem_write_enable = 1, mem_data_out = merged word (SW: req_wdata).
  - Exactly one cycle, then DONE.
  - mem_data_in_v is ignored.
- DONE: resp_valid = 1 and resp_rdata / resp_error held for one cycle, then IDLE.
- mem_enable = 0 outside READ/WRITE. mem_data_out = 0 outside WRITE.
- Latency, accept on edge N:
  - SW: write cycle N+1, resp cycle N+2.
  - Load with valid on the first READ cycle: resp cycle N+2.
  - SB/SH with immediate valid: write cycle N+2, resp cycle N+3.
  - Error on accept: resp cycle N+1.
- Back-to-back: the next request can be accepted the cycle after resp_valid (IDLE).

Test Plan:
- SW addr=4 wdata=ABCDABCD, then LW addr=4 (memory returns valid the cycle after enable) -> one write of ABCDABCD to word 4; LW resp_rdata=ABCDABCD, error=0.
- Memory word 8 = CDEFCDEF; LB addr=9 -> FFFFFFCD; LBU addr=9 -> 000000CD; LH addr=10 -> FFFFCDEF; LHU addr=10 -> 0000CDEF.
- Word 8 = CDEFCDEF; SB addr=10 wdata=0x12 -> read of 8, then write CD12CDEF; SH addr=8 wdata=0x3456 -> write CDEF3456 (after SB: CD123456).
- LW addr=6, then SH addr=5 -> resp_error=1 one cycle after accept; mem_enable never asserted.
- LW with mem_data_in_v held low -> after 16 READ cycles, resp_error=1, resp_rdata=0, no write.
- Assert rst during READ of SB -> IDLE next edge, req_ready=1, mem_enable=0, no write issued.
